// File: rtl/ysyx_24100005_mem_arb.sv
// Round-robin arbiter sharing one data-memory port between IFU and LSU.
// One transaction outstanding; LSU stores are lane-aligned, loads are extracted and extended.
module ysyx_24100005_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  output logic              ifu_rsp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [1:0]        lsu_req_size,
  input  logic              lsu_req_sext,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              lsu_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

  state_t              state, state_nxt;
  logic                last_grant_lsu;
  logic                owner_lsu_p1;
  logic                grant_ifu, grant_lsu, accept, req_bad;
  logic [ADDR_W-1:0]   req_addr;

  logic [ADDR_W-1:0]   addr_p1;
  logic [1:0]          off_p1;
  logic [1:0]          size_p1;
  logic                sext_p1;
  logic                wen_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [MASK_W-1:0]   wmask_p1;
  logic [DATA_W-1:0]   rsp_data_p2;

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lsu_misaligned = 1'b0;
      2'd1:    lsu_misaligned = off[0];
      2'd2:    lsu_misaligned = (off != 2'd0);
      default: lsu_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [MASK_W-1:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    store_mask = MASK_W'(1) << off;
      2'd1:    store_mask = MASK_W'(3) << off;
      2'd2:    store_mask = '1;
      default: store_mask = '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [DATA_W-1:0] wdata, input logic [1:0] off);
    store_data = wdata << {off, 3'b000};
  endfunction

  function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] rdata, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sext);
    logic [DATA_W-1:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (size)
      2'd0:    load_fmt = {{(DATA_W-8){sext & shifted[7]}}, shifted[7:0]};
      2'd1:    load_fmt = {{(DATA_W-16){sext & shifted[15]}}, shifted[15:0]};
      2'd2:    load_fmt = shifted;
      default: load_fmt = '0;
    endcase
  endfunction

  // Grant: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE) begin
      if (ifu_req_valid && (!lsu_req_valid || last_grant_lsu)) grant_ifu = 1'b1;
      else if (lsu_req_valid)                                  grant_lsu = 1'b1;
    end
  end

  assign accept        = grant_ifu | grant_lsu;
  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign req_addr      = grant_lsu ? lsu_req_addr : ifu_req_addr;
  assign req_bad       = grant_lsu ? lsu_misaligned(lsu_req_size, lsu_req_addr[1:0])
                                   : (ifu_req_addr[1:0] != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      last_grant_lsu <= 1'b1;
      owner_lsu_p1   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant_lsu <= grant_lsu;
        owner_lsu_p1   <= grant_lsu;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = req_bad ? S_ERR : S_REQ;
      S_REQ:   if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (mem_rsp_valid) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: captured request; stage p2: formatted response. Outputs are gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= {req_addr[ADDR_W-1:2], 2'b00};
      off_p1   <= req_addr[1:0];
      size_p1  <= lsu_req_size;
      sext_p1  <= lsu_req_sext;
      wen_p1   <= grant_lsu & lsu_req_wen;
      wdata_p1 <= (grant_lsu & lsu_req_wen) ? store_data(lsu_req_wdata, lsu_req_addr[1:0]) : '0;
      wmask_p1 <= (grant_lsu & lsu_req_wen) ? store_mask(lsu_req_size, lsu_req_addr[1:0]) : '0;
    end
    if (state == S_WAIT && mem_rsp_valid) begin
      if (!owner_lsu_p1) rsp_data_p2 <= mem_rsp_rdata;
      else if (wen_p1)   rsp_data_p2 <= '0;
      else               rsp_data_p2 <= load_fmt(mem_rsp_rdata, off_p1, size_p1, sext_p1);
    end
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = '0;
    ifu_rsp_err   = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_data  = '0;
    lsu_rsp_err   = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_p1;
        mem_req_wen   = wen_p1;
        mem_req_wdata = wdata_p1;
        mem_req_wmask = wmask_p1;
      end
      S_RESP: begin
        if (owner_lsu_p1) begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp_data  = rsp_data_p2;
        end else begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp_data  = rsp_data_p2;
        end
      end
      S_ERR: begin
        if (owner_lsu_p1) begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp_err   = 1'b1;
        end else begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp_err   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100005_mem_arb.sv
// Directed bench for ysyx_24100005_mem_arb: arbitration, store/load formatting,
// misalignment errors and reset abort, with hand-computed expected values.
module tb_ysyx_24100005_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_req_sext;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [1:0]  lsu_req_size;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_24100005_mem_arb dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_size  (lsu_req_size),
    .lsu_req_sext  (lsu_req_sext),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_data  (lsu_rsp_data),
    .lsu_rsp_err   (lsu_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .busy          (busy)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction starting in IDLE, just after a rising edge.
  task automatic run(input string tag, input bit ifu_v, input bit lsu_v, input bit exp_lsu,
                     input logic [31:0] ifu_a, input logic [31:0] lsu_a, input bit wen,
                     input logic [31:0] wdata, input logic [1:0] size, input bit sext,
                     input logic [31:0] rdata, input logic [31:0] exp_maddr,
                     input logic [31:0] exp_mwdata, input logic [3:0] exp_mask,
                     input logic [31:0] exp_data, input bit exp_err);
    ifu_req_valid = ifu_v;
    ifu_req_addr  = ifu_a;
    lsu_req_valid = lsu_v;
    lsu_req_addr  = lsu_a;
    lsu_req_wen   = wen;
    lsu_req_wdata = wdata;
    lsu_req_size  = size;
    lsu_req_sext  = sext;
    @(negedge clk);
    chk_eq({tag, ".ifu_rdy"}, 32'(ifu_req_ready), 32'(ifu_v && !exp_lsu));
    chk_eq({tag, ".lsu_rdy"}, 32'(lsu_req_ready), 32'(exp_lsu));
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    if (exp_err) begin
      @(negedge clk);
      chk_eq({tag, ".mreq_v"}, 32'(mem_req_valid), 32'd0);
      chk_eq({tag, ".rsp_v"}, 32'(exp_lsu ? lsu_rsp_valid : ifu_rsp_valid), 32'd1);
      chk_eq({tag, ".rsp_err"}, 32'(exp_lsu ? lsu_rsp_err : ifu_rsp_err), 32'd1);
      chk_eq({tag, ".rsp_data"}, exp_lsu ? lsu_rsp_data : ifu_rsp_data, 32'd0);
      chk_eq({tag, ".other_v"}, 32'(exp_lsu ? ifu_rsp_valid : lsu_rsp_valid), 32'd0);
      @(posedge clk); #1;
    end else begin
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk_eq({tag, ".mreq_v"}, 32'(mem_req_valid), 32'd1);
      chk_eq({tag, ".maddr"}, mem_req_addr, exp_maddr);
      chk_eq({tag, ".mwen"}, 32'(mem_req_wen), 32'(exp_lsu && wen));
      chk_eq({tag, ".mwdata"}, mem_req_wdata, exp_mwdata);
      chk_eq({tag, ".mwmask"}, 32'(mem_req_wmask), 32'(exp_mask));
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      @(negedge clk);
      chk_eq({tag, ".early_v"}, 32'(ifu_rsp_valid | lsu_rsp_valid), 32'd0);
      chk_eq({tag, ".busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk_eq({tag, ".rsp_v"}, 32'(exp_lsu ? lsu_rsp_valid : ifu_rsp_valid), 32'd1);
      chk_eq({tag, ".rsp_err"}, 32'(exp_lsu ? lsu_rsp_err : ifu_rsp_err), 32'd0);
      chk_eq({tag, ".rsp_data"}, exp_lsu ? lsu_rsp_data : ifu_rsp_data, exp_data);
      chk_eq({tag, ".other_v"}, 32'(exp_lsu ? ifu_rsp_valid : lsu_rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    lsu_req_valid = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wen   = 1'b0;
    lsu_req_wdata = '0;
    lsu_req_size  = 2'd0;
    lsu_req_sext  = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst.ifu_rdy",  32'(ifu_req_ready), 32'd0);
    chk_eq("rst.lsu_rdy",  32'(lsu_req_ready), 32'd0);
    chk_eq("rst.ifu_rsp",  32'(ifu_rsp_valid), 32'd0);
    chk_eq("rst.lsu_rsp",  32'(lsu_rsp_valid), 32'd0);
    chk_eq("rst.mreq_v",   32'(mem_req_valid), 32'd0);
    chk_eq("rst.maddr",    mem_req_addr, 32'd0);
    chk_eq("rst.mwmask",   32'(mem_req_wmask), 32'd0);
    chk_eq("rst.busy",     32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Simultaneous requests after reset: IFU, LSU, IFU, LSU.
    run("arb0", 1, 1, 0, 32'h8000_0004, 32'h8000_0010, 0, 32'h0, 2'd2, 0, 32'h1111_1111,
        32'h8000_0004, 32'h0, 4'h0, 32'h1111_1111, 0);
    run("arb1", 1, 1, 1, 32'h8000_0004, 32'h8000_0010, 0, 32'h0, 2'd2, 0, 32'h2222_2222,
        32'h8000_0010, 32'h0, 4'h0, 32'h2222_2222, 0);
    run("arb2", 1, 1, 0, 32'h8000_0008, 32'h8000_0014, 0, 32'h0, 2'd2, 0, 32'h3333_3333,
        32'h8000_0008, 32'h0, 4'h0, 32'h3333_3333, 0);
    run("arb3", 1, 1, 1, 32'h8000_0008, 32'h8000_0014, 0, 32'h0, 2'd2, 0, 32'h4444_4444,
        32'h8000_0014, 32'h0, 4'h0, 32'h4444_4444, 0);

    run("ifu",  1, 0, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 2'd0, 0, 32'h0010_0093,
        32'h8000_0000, 32'h0, 4'h0, 32'h0010_0093, 0);
    run("sb",   0, 1, 1, 32'h0, 32'h8000_0003, 1, 32'h0000_00AB, 2'd0, 0, 32'hDEAD_BEEF,
        32'h8000_0000, 32'hAB00_0000, 4'h8, 32'h0, 0);
    run("sh",   0, 1, 1, 32'h0, 32'h8000_0006, 1, 32'h0000_1234, 2'd1, 0, 32'h0,
        32'h8000_0004, 32'h1234_0000, 4'hC, 32'h0, 0);
    run("sw",   0, 1, 1, 32'h0, 32'h8000_0008, 1, 32'hCAFE_F00D, 2'd2, 0, 32'h0,
        32'h8000_0008, 32'hCAFE_F00D, 4'hF, 32'h0, 0);
    run("lhs",  0, 1, 1, 32'h0, 32'h8000_0002, 0, 32'h0, 2'd1, 1, 32'h8001_1234,
        32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_8001, 0);
    run("lhu",  0, 1, 1, 32'h0, 32'h8000_0002, 0, 32'h0, 2'd1, 0, 32'h8001_1234,
        32'h8000_0000, 32'h0, 4'h0, 32'h0000_8001, 0);
    run("lbs",  0, 1, 1, 32'h0, 32'h8000_0001, 0, 32'h0, 2'd0, 1, 32'h0000_F500,
        32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_FFF5, 0);
    run("lbu",  0, 1, 1, 32'h0, 32'h8000_0003, 0, 32'h0, 2'd0, 0, 32'h9A00_0000,
        32'h8000_0000, 32'h0, 4'h0, 32'h0000_009A, 0);
    run("lw_mis",  0, 1, 1, 32'h0, 32'h8000_0001, 0, 32'h0, 2'd2, 0, 32'h0,
        32'h0, 32'h0, 4'h0, 32'h0, 1);
    run("lh_mis",  0, 1, 1, 32'h0, 32'h8000_0003, 0, 32'h0, 2'd1, 1, 32'h0,
        32'h0, 32'h0, 4'h0, 32'h0, 1);
    run("size3",   0, 1, 1, 32'h0, 32'h8000_0004, 0, 32'h0, 2'd3, 0, 32'h0,
        32'h0, 32'h0, 4'h0, 32'h0, 1);
    run("ifu_mis", 1, 0, 0, 32'h8000_0002, 32'h0, 0, 32'h0, 2'd0, 0, 32'h0,
        32'h0, 32'h0, 4'h0, 32'h0, 1);

    // Abort while waiting for the backend; the late response must be dropped.
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0020;
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk_eq("abort.busy_wait", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_eq("abort.busy_rst", 32'(busy), 32'd0);
    chk_eq("abort.mreq_v",   32'(mem_req_valid), 32'd0);
    @(posedge clk); #1;
    rst           = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk_eq("abort.late_rsp", 32'(ifu_rsp_valid | lsu_rsp_valid), 32'd0);
    chk_eq("abort.busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk_eq("abort.no_rsp", 32'(ifu_rsp_valid | lsu_rsp_valid), 32'd0);
    @(posedge clk); #1;
    run("post_rst", 1, 0, 0, 32'h8000_0024, 32'h0, 0, 32'h0, 2'd0, 0, 32'h0000_0013,
        32'h8000_0024, 32'h0, 4'h0, 32'h0000_0013, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
